// File: rtl/frame_display_buffer.sv
// frame_display_buffer
//   Stores the filtered pixel stream in an on-chip frame store. It replays the
//   stored frame with VGA-style raster timing on the pixel clock. The image is
//   centred via X_OFF/Y_OFF. Active pixels outside the image show BORDER.
//   Optional feature macro: FRAME_DOUBLE_BUF_EN.
//     When defined, the store has two banks and the banks swap at a raster
//     frame start, so the display never tears.
//     When undefined, one bank is shared by the writer and scan-out.
module frame_display_buffer #(
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X_OFF    = 192,
  parameter int unsigned Y_OFF    = 112,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_SYNC_S = 656,
  parameter int unsigned H_SYNC_E = 752,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_SYNC_S = 490,
  parameter int unsigned V_SYNC_E = 492,
  parameter int unsigned V_TOTAL  = 525,
  parameter logic [7:0]  BORDER   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  output logic       frame_done,
  output logic       frame_ready,
  output logic [7:0] pix_out,
  output logic       draw_area,
  output logic       hsync,
  output logic       vsync
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int AW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
`ifdef FRAME_DOUBLE_BUF_EN
  localparam int MW    = AW + 1;
  localparam int MEM_D = 2 ** MW;
`else
  localparam int MW    = AW;
  localparam int MEM_D = NPIX;
`endif

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  // ---------------- write side ----------------
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          frame_done_q, frame_ready_q;
  logic          last_wr;

  assign last_wr = pix_valid && (wr_addr_q == AW'(NPIX - 1));

  // next write address: advance per accepted pixel, wrap after the last one
  always_comb begin
    wr_addr_d = wr_addr_q;
    if (pix_valid) wr_addr_d = last_wr ? '0 : wr_addr_q + AW'(1);
  end

  // write pointer and frame-complete flags; reset abandons any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= last_wr;
      if (last_wr) frame_ready_q <= 1'b1;
    end
  end

  // ---------------- raster counters ----------------
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   h32, v32, hx, vy;
  logic          h_last, v_last, frame_start, in_h, in_v, in_img, active, hs, vs;

  assign h32         = 32'(h_q);
  assign v32         = 32'(v_q);
  assign h_last      = (h32 == H_TOTAL - 1);
  assign v_last      = (v32 == V_TOTAL - 1);
  assign frame_start = (h_q == '0) && (v_q == '0);
  // offset-relative coordinates; wrap to huge values left/above the image
  assign hx          = h32 - X_OFF;
  assign vy          = v32 - Y_OFF;
  assign in_h        = hx < IMG_W;
  assign in_v        = vy < IMG_H;
  assign in_img      = in_h && in_v;
  assign active      = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
  assign hs          = (h32 >= H_SYNC_S) && (h32 < H_SYNC_E);
  assign vs          = (v32 >= V_SYNC_S) && (v32 < V_SYNC_E);

  // free-running scan position
  always_comb begin
    h_d = h_last ? '0 : h_q + HW'(1);
    v_d = v_q;
    if (h_last) v_d = v_last ? '0 : v_q + VW'(1);
  end

  // scan position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // ---------------- read address ----------------
  logic [AW-1:0] row_base_q, row_base_d, rd_addr;

  assign rd_addr = row_base_q + AW'(hx);

  // line base steps by IMG_W after each image line, so no multiplier is needed
  always_comb begin
    row_base_d = row_base_q;
    if (h_last && v_last)   row_base_d = '0;
    else if (h_last && in_v) row_base_d = row_base_q + AW'(IMG_W);
  end

  // row base register
  always_ff @(posedge clk) begin
    if (rst) row_base_q <= '0;
    else     row_base_q <= row_base_d;
  end

  // ---------------- bank control / display enable ----------------
  logic [MW-1:0] wr_ptr, rd_ptr;
  logic          show_go;

`ifdef FRAME_DOUBLE_BUF_EN
  logic wb_q, wb_d, swap_pend_q, swap_pend_d, swap;

  assign swap = frame_start && swap_pend_q;

  // swap banks only at a raster frame start; a frame finishing on the swap
  // cycle lands in the new write bank, so it stays pending
  always_comb begin
    wb_d        = wb_q ^ swap;
    swap_pend_d = swap_pend_q;
    if (last_wr)   swap_pend_d = 1'b1;
    else if (swap) swap_pend_d = 1'b0;
  end

  // bank select and pending-swap registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q        <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      swap_pend_q <= swap_pend_d;
    end
  end

  // the post-swap bank is used on the swap cycle itself for both ports
  assign wr_ptr  = {wb_d, wr_addr_q};
  assign rd_ptr  = {~wb_d, rd_addr};
  assign show_go = swap;
`else
  assign wr_ptr  = wr_addr_q;
  assign rd_ptr  = rd_addr;
  assign show_go = frame_start && frame_ready_q;
`endif

  state_t state_q, state_d;

  // display enable: leave BLANK only at a frame start, never mid-frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (show_go) state_d = ST_SHOW;
      ST_SHOW:  state_d = ST_SHOW;
      default:  state_d = ST_BLANK;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BLANK;
    else     state_q <= state_d;
  end

  // ---------------- frame store ----------------
  logic [7:0] mem [MEM_D];
  logic [7:0] rd_data_q;

  // single write port, registered read port; read-first on an address collision
  always_ff @(posedge clk) begin
    if (!rst && pix_valid) mem[wr_ptr] <= pix_in;
    rd_data_q <= mem[rd_ptr];
  end

  // ---------------- output pipeline ----------------
  logic       hs1_q, vs1_q, act1_q, img1_q;
  logic       hsync_q, vsync_q, draw_q;
  logic [7:0] pix_q, pix_d;

  // pick the pixel value: blank, stored image, or border
  always_comb begin
    pix_d = 8'h00;
    if (act1_q) pix_d = (img1_q && state_q == ST_SHOW) ? rd_data_q : BORDER;
  end

  // stage 1 tracks the read in flight; stage 2 aligns every output to it
  always_ff @(posedge clk) begin
    if (rst) begin
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      act1_q  <= 1'b0;
      img1_q  <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      draw_q  <= 1'b0;
      pix_q   <= 8'h00;
    end else begin
      hs1_q   <= hs;
      vs1_q   <= vs;
      act1_q  <= active;
      img1_q  <= in_img;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
      draw_q  <= act1_q;
      pix_q   <= pix_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_ready = frame_ready_q;
  assign pix_out     = pix_q;
  assign draw_area   = draw_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;

endmodule
